// File: rtl/bus_arbiter.sv
// Purpose: two-slot time-division arbiter that shares one RAM/IO bus between the SPI command engine (slot A) and the 6502 CPU (slot B).
// Latency: an MCU request is acked SLOT_CLOCKS..3*SLOT_CLOCKS clocks after it is sampled; cpu_en_o fires once every 2*SLOT_CLOCKS clocks; all outputs are registered.
// Backpressure: the MCU holds spi_cycle_i until spi_ack_o. cpu_halt_i idles the CPU slot; with CPU_SLOT_STEAL_EN defined, the idle CPU slot is lent to the MCU instead.
//
// Ports:
//   clk_i, reset_i                  clock and async active-high reset
//   spi_addr_i/_wr_data_i/_we_i     MCU request fields; spi_cycle_i is the request level; spi_ack_o is a 1-clock done pulse
//   cpu_addr_i/_wr_data_i/_we_i     CPU request fields; cpu_halt_i idles the CPU slot; cpu_en_o is the CPU cycle-enable pulse
//   rd_data_o                       last captured read data
//   ram_addr_o, ram_data_o          bus address and write data
//   ram_data_i, ram_data_oe_o       bus read data and write-data drive enable
//   ram_oe_no, ram_we_no            RAM strobes, active low
module bus_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 17,
  parameter int SLOT_CLOCKS = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [ADDR_WIDTH-1:0] spi_addr_i,
  input  logic [DATA_WIDTH-1:0] spi_wr_data_i,
  input  logic                  spi_we_i,
  input  logic                  spi_cycle_i,
  output logic                  spi_ack_o,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wr_data_i,
  input  logic                  cpu_we_i,
  input  logic                  cpu_halt_i,
  output logic                  cpu_en_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic                  ram_data_oe_o,
  output logic                  ram_oe_no,
  output logic                  ram_we_no
);

  localparam int PW = $clog2(2 * SLOT_CLOCKS);
  localparam logic [PW-1:0] LAST_PHASE = PW'(2 * SLOT_CLOCKS - 1);
  localparam logic [PW-1:0] SLOT_P     = PW'(SLOT_CLOCKS);
  localparam logic [PW-1:0] P_STRB_ON  = PW'(2);
  localparam logic [PW-1:0] P_WE_LAST  = PW'(SLOT_CLOCKS - 3);
  localparam logic [PW-1:0] P_RD_LAST  = PW'(SLOT_CLOCKS - 2);
  localparam logic [PW-1:0] P_END      = PW'(SLOT_CLOCKS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_SPI = 2'd1,
    GRANT_CPU = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] phase;
  logic [PW-1:0] phase_nxt;
  logic [PW-1:0] p_nxt;
  logic          slot_b_nxt;
  logic          we_q;
  logic          served;
  logic          busy;
  logic          spi_eligible;

  // Every registered output describes the cycle being entered, so all
  // decisions are made on the phase the counter is about to take.
  always_comb begin
    phase_nxt  = (phase == LAST_PHASE) ? '0 : phase + 1'b1;
    slot_b_nxt = (phase_nxt >= SLOT_P);
    p_nxt      = slot_b_nxt ? (phase_nxt - SLOT_P) : phase_nxt;
  end

  assign busy         = (state != IDLE);
  // served masks a request that is still high only because the upstream
  // clear lags its view of the ack by one clock.
  assign spi_eligible = spi_cycle_i && !served;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      phase         <= '0;
      state         <= IDLE;
      we_q          <= 1'b0;
      served        <= 1'b0;
      spi_ack_o     <= 1'b0;
      cpu_en_o      <= 1'b0;
      rd_data_o     <= '0;
      ram_addr_o    <= '0;
      ram_data_o    <= '0;
      ram_data_oe_o <= 1'b0;
      ram_oe_no     <= 1'b1;
      ram_we_no     <= 1'b1;
    end else begin
      phase     <= phase_nxt;
      spi_ack_o <= 1'b0;
      cpu_en_o  <= 1'b0;
      if (!spi_cycle_i) begin
        served <= 1'b0;
      end

      if (p_nxt == '0) begin
        // Slot boundary: strobes off, grant decided and latched for the slot.
        ram_oe_no     <= 1'b1;
        ram_we_no     <= 1'b1;
        ram_data_oe_o <= 1'b0;
        if (!slot_b_nxt) begin
          if (spi_eligible) begin
            state      <= GRANT_SPI;
            we_q       <= spi_we_i;
            ram_addr_o <= spi_addr_i;
            ram_data_o <= spi_wr_data_i;
          end else begin
            state <= IDLE;
          end
        end else if (!cpu_halt_i) begin
          state      <= GRANT_CPU;
          we_q       <= cpu_we_i;
          ram_addr_o <= cpu_addr_i;
          ram_data_o <= cpu_wr_data_i;
        end
`ifdef CPU_SLOT_STEAL_EN
        else if (spi_eligible) begin
          state      <= GRANT_SPI;
          we_q       <= spi_we_i;
          ram_addr_o <= spi_addr_i;
          ram_data_o <= spi_wr_data_i;
        end
`endif
        else begin
          state <= IDLE;
        end
      end else begin
        // Data drive and OE span p=1..SLOT_CLOCKS-2; WE sits one clock
        // inside that window on both sides for address/data setup and hold.
        ram_oe_no     <= !(busy && !we_q && (p_nxt <= P_RD_LAST));
        ram_data_oe_o <= busy && we_q && (p_nxt <= P_RD_LAST);
        ram_we_no     <= !(busy && we_q && (p_nxt >= P_STRB_ON) && (p_nxt <= P_WE_LAST));
        if (p_nxt == P_END) begin
          if (busy && !we_q) begin
            rd_data_o <= ram_data_i;
          end
          if (state == GRANT_SPI) begin
            spi_ack_o <= 1'b1;
            if (spi_cycle_i) begin
              served <= 1'b1;
            end
          end
          cpu_en_o <= (state == GRANT_CPU);
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Purpose: self-checking bench for bus_arbiter (vector table, corner sequences, randomized traffic against a slot-level model).
// Latency: checks outputs on the falling edge of each clock; inputs change on the same falling edge.
// Backpressure: the MCU stand-in holds its request until it sees spi_ack_o and drops it one clock later.
module tb_bus_arbiter;
  localparam int DW    = 8;
  localparam int AW    = 17;
  localparam int SC    = 32;
  localparam int PER   = 2 * SC;
  localparam int NRAND = 40 * PER;
`ifdef CPU_SLOT_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  logic          clk_i         = 1'b0;
  logic          reset_i       = 1'b0;
  logic [AW-1:0] spi_addr_i    = '0;
  logic [DW-1:0] spi_wr_data_i = '0;
  logic          spi_we_i      = 1'b0;
  logic          spi_cycle_i   = 1'b0;
  logic          spi_ack_o;
  logic [AW-1:0] cpu_addr_i    = '0;
  logic [DW-1:0] cpu_wr_data_i = '0;
  logic          cpu_we_i      = 1'b0;
  logic          cpu_halt_i    = 1'b0;
  logic          cpu_en_o;
  logic [DW-1:0] rd_data_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_data_o;
  logic [DW-1:0] ram_data_i;
  logic          ram_data_oe_o;
  logic          ram_oe_no;
  logic          ram_we_no;

  bus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLOT_CLOCKS(SC)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .spi_addr_i(spi_addr_i), .spi_wr_data_i(spi_wr_data_i), .spi_we_i(spi_we_i),
    .spi_cycle_i(spi_cycle_i), .spi_ack_o(spi_ack_o),
    .cpu_addr_i(cpu_addr_i), .cpu_wr_data_i(cpu_wr_data_i), .cpu_we_i(cpu_we_i),
    .cpu_halt_i(cpu_halt_i), .cpu_en_o(cpu_en_o), .rd_data_o(rd_data_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
    .ram_data_oe_o(ram_data_oe_o), .ram_oe_no(ram_oe_no), .ram_we_no(ram_we_no)
  );

  always #5 clk_i = ~clk_i;

  // RAM: drives data while OE is low, latches on the rising edge of WE.
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  assign ram_data_i = !ram_oe_no ? mem[ram_addr_o] : 8'hEE;
  always @(posedge ram_we_no) begin
    if (!reset_i && ram_data_oe_o) mem[ram_addr_o] = ram_data_o;
  end

  // Clocks since reset release; equals the arbiter phase modulo PER.
  int cyc;
  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    spi_cycle_i = 1'b0;
    spi_we_i    = 1'b0;
    cpu_halt_i  = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = '0;
    @(negedge clk_i);
    reset_i = 1'b1;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 15));
    if ($urandom_range(0, 1) == 1) a[AW-1] = 1'b1;
    return a;
  endfunction

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdat;
    logic [DW-1:0] init;
    int            start;
    logic          halt;
    int            drop_at;
    int            exp_ack;
    int            exp_en;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int ack_cnt = 0, ack_at = -1, en_cnt = 0, first_s = -1, last_s = -1, g;
    logic [DW-1:0] rd_at = '0, dat_ack = '0;
    logic [AW-1:0] addr_g = '0, addr_ack = '0;
    logic strobe_n;
    do_reset();
    mem[v.addr] = v.init;
    cpu_halt_i  = v.halt;
    g = v.exp_ack - (SC - 1);
    while (cyc < 200) begin
      if (spi_ack_o) begin
        ack_cnt++;
        if (ack_at < 0) begin
          ack_at = cyc; rd_at = rd_data_o; addr_ack = ram_addr_o; dat_ack = ram_data_o;
        end
      end
      if (cpu_en_o) en_cnt++;
      if (cyc == g) addr_g = ram_addr_o;
      strobe_n = v.we ? ram_we_no : ram_oe_no;
      if (!strobe_n && cyc >= g && cyc <= v.exp_ack) begin
        if (first_s < 0) first_s = cyc;
        last_s = cyc;
      end
      if (cyc == v.start) begin
        spi_cycle_i = 1'b1; spi_we_i = v.we; spi_addr_i = v.addr; spi_wr_data_i = v.wdat;
      end else if (spi_cycle_i && (cyc == v.drop_at || (ack_at >= 0 && cyc > ack_at))) begin
        spi_cycle_i = 1'b0;
      end
      @(negedge clk_i);
    end
    check($sformatf("v%0d_ack_cycle", idx), 32'(ack_at), 32'(v.exp_ack));
    check($sformatf("v%0d_ack_count", idx), 32'(ack_cnt), 32'd1);
    check($sformatf("v%0d_cpu_en_count", idx), 32'(en_cnt), 32'(v.exp_en));
    check($sformatf("v%0d_addr_slot_start", idx), 32'(addr_g), 32'(v.addr));
    check($sformatf("v%0d_addr_at_ack", idx), 32'(addr_ack), 32'(v.addr));
    check($sformatf("v%0d_strobe_first", idx), 32'(first_s), 32'(v.we ? v.exp_ack - 29 : v.exp_ack - 30));
    check($sformatf("v%0d_strobe_last", idx), 32'(last_s), 32'(v.we ? v.exp_ack - 2 : v.exp_ack - 1));
    if (v.we) begin
      check($sformatf("v%0d_wdata_at_ack", idx), 32'(dat_ack), 32'(v.wdat));
      check($sformatf("v%0d_ram_written", idx), 32'(mem[v.addr]), 32'(v.wdat));
    end else begin
      check($sformatf("v%0d_rd_data", idx), 32'(rd_at), 32'(v.init));
    end
  endtask

  // Slot-level model: each slot has one owner (0 none, 1 MCU, 2 CPU) chosen
  // from the inputs seen at the slot boundary; outputs follow from owner and offset.
  task automatic run_random();
    int owner = 0, gap = 0, ph, p;
    bit pending = 0, drop_next = 0, act;
    logic m_we = 1'b0;
    logic [AW-1:0] m_addr = '0, last_addr = '0;
    logic [DW-1:0] m_data = '0, last_data = '0, m_rd = '0;
    logic [4:0] exp_v;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = mem[i];
    do_reset();
    while (cyc < NRAND) begin
      ph  = cyc % PER;
      p   = ph % SC;
      act = (owner != 0);
      if (act && p == SC - 1) begin
        if (m_we) ref_mem[m_addr] = m_data;
        else      m_rd = ref_mem[m_addr];
        if (owner == 1) pending = 0;
      end
      exp_v = {owner == 1 && p == SC - 1,
               owner == 2 && p == SC - 1,
               !(act && !m_we && p >= 1 && p <= SC - 2),
               !(act && m_we && p >= 2 && p <= SC - 3),
               act && m_we && p >= 1 && p <= SC - 2};
      check("rand_ack_en_oe_we_doe", 32'({spi_ack_o, cpu_en_o, ram_oe_no, ram_we_no, ram_data_oe_o}), 32'(exp_v));
      check("rand_ram_addr", 32'(ram_addr_o), 32'(last_addr));
      check("rand_ram_wdata", 32'(ram_data_o), 32'(last_data));
      check("rand_rd_data", 32'(rd_data_o), 32'(m_rd));

      if (spi_cycle_i) begin
        if (drop_next) begin
          spi_cycle_i = 1'b0; drop_next = 0; gap = $urandom_range(1, 80);
        end else if (spi_ack_o) begin
          drop_next = 1;
        end
      end else if (gap > 0) begin
        gap--;
      end else begin
        spi_cycle_i   = 1'b1;
        spi_we_i      = 1'($urandom_range(0, 1));
        spi_addr_i    = rand_addr();
        spi_wr_data_i = 8'($urandom);
        pending       = 1;
      end
      cpu_halt_i    = ($urandom_range(0, 2) == 0);
      cpu_we_i      = 1'($urandom_range(0, 1));
      cpu_addr_i    = rand_addr();
      cpu_wr_data_i = 8'($urandom);

      if ((cyc + 1) % SC == 0) begin
        if ((cyc + 1) % PER == 0)  owner = (pending && spi_cycle_i) ? 1 : 0;
        else if (!cpu_halt_i)      owner = 2;
        else                       owner = (STEAL && pending && spi_cycle_i) ? 1 : 0;
        if (owner == 1) begin
          m_we = spi_we_i; m_addr = spi_addr_i; m_data = spi_wr_data_i;
        end else if (owner == 2) begin
          m_we = cpu_we_i; m_addr = cpu_addr_i; m_data = cpu_wr_data_i;
        end
        if (owner != 0) begin
          last_addr = m_addr; last_data = m_data;
        end
      end
      @(negedge clk_i);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int en_cnt, en_off, ack_cnt;

    vecs[0] = '{1'b0, 17'h18000, 8'h00, 8'hA5,  1, 1'b0, -1,  95, 3};
    vecs[1] = '{1'b1, 17'h00400, 8'h3C, 8'h11,  1, 1'b0, -1,  95, 3};
    vecs[2] = '{1'b0, 17'h0ABCD, 8'h00, 8'h5A,  5, 1'b0, -1,  95, 3};
    vecs[3] = '{1'b0, 17'h1FFFF, 8'h00, 8'hC3, 63, 1'b0, -1,  95, 3};
    vecs[4] = '{1'b0, 17'h00001, 8'h00, 8'h77, 64, 1'b0, -1, 159, 3};
    vecs[5] = '{1'b0, 17'h12345, 8'h00, 8'h96, 10, 1'b1, -1, STEAL ? 63 : 95, 0};
    vecs[6] = '{1'b1, 17'h00777, 8'hE1, 8'h0F, 64, 1'b1, -1, STEAL ? 127 : 159, 0};
    vecs[7] = '{1'b0, 17'h00042, 8'h00, 8'h3D,  1, 1'b0, 70,  95, 3};

    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);

    #1 reset_i = 1'b1;
    #1;
    check("reset_ack_en_oe_we_doe", 32'({spi_ack_o, cpu_en_o, ram_oe_no, ram_we_no, ram_data_oe_o}), 32'(5'b00110));
    check("reset_ram_addr", 32'(ram_addr_o), 32'd0);
    check("reset_ram_data", 32'(ram_data_o), 32'd0);
    check("reset_rd_data", 32'(rd_data_o), 32'd0);

    // Idle bus, CPU running: cpu_en_o at phase 63 of every period, no acks.
    do_reset();
    en_cnt = 0; en_off = 0; ack_cnt = 0;
    while (cyc < 200) begin
      if (cpu_en_o) begin
        en_cnt++;
        if (cyc % PER != PER - 1) en_off++;
      end
      if (spi_ack_o) ack_cnt++;
      @(negedge clk_i);
    end
    check("idle_cpu_en_count", 32'(en_cnt), 32'd3);
    check("idle_cpu_en_off_phase", 32'(en_off), 32'd0);
    check("idle_spi_ack_count", 32'(ack_cnt), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset at slot-A p=10 of an MCU write: strobes drop at once, no ack, RAM untouched.
    do_reset();
    mem[17'h00555] = 8'h42;
    while (cyc < 74) begin
      if (cyc == 1) begin
        spi_cycle_i = 1'b1; spi_we_i = 1'b1; spi_addr_i = 17'h00555; spi_wr_data_i = 8'h99;
      end
      @(negedge clk_i);
    end
    check("rst_pre_we_n", 32'(ram_we_no), 32'd0);
    #2 reset_i = 1'b1;
    #1;
    check("rst_async_we_doe_oe_ack", 32'({ram_we_no, ram_data_oe_o, ram_oe_no, spi_ack_o}), 32'(4'b1010));
    spi_cycle_i = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    ack_cnt = 0;
    while (cyc < 150) begin
      if (spi_ack_o) ack_cnt++;
      @(negedge clk_i);
    end
    check("rst_no_ack", 32'(ack_cnt), 32'd0);
    check("rst_ram_unchanged", 32'(mem[17'h00555]), 32'h42);

    run_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
